glm_c1_write_arbiter: RTL
=========================

// Module: glm_c1_write_arbiter
// PURPOSE
//  Shares the single CCI-P c1 (write) TX channel among NUM_REQ writeback engines, each issuing single-line writes.
//  Sits between the engines and the AFU c1 port: buffers each requester, arbitrates round-robin and tags each write.
//  Routes each write response back to its issuing engine by that tag.
//  Per-engine back-pressure uses the same almost-full contract the engines already honour on c1TxAlmFull.
// PARAMETERS
//  NUM_REQ        4   number of requesters (2..16); ID_BITS = $clog2(NUM_REQ) derived localparam
//  FIFO_DEPTH     16  per-requester request FIFO entries (power of 2)
//  ALMFULL_SLACK  8   req_almfull[i] asserts when fill >= FIFO_DEPTH-ALMFULL_SLACK (covers engine pipeline latency)
// PORTS
//  clk            in   1                 clock
//  reset          in   1                 synchronous, active-high
//  req_sTx_c1     in   t_if_ccip_c1_Tx[NUM_REQ]  per-engine write request (valid one-shot, no ready)
//  req_almfull    out  NUM_REQ           per-engine back-pressure
//  req_sRx_c1     out  t_if_ccip_c1_Rx[NUM_REQ]  per-engine routed write response
//  c1TxAlmFull    in   1                 shell back-pressure
//  af2cp_sTx_c1   out  t_if_ccip_c1_Tx   to shell
//  cp2af_sRx_c1   in   t_if_ccip_c1_Rx   from shell
//  outstanding    out  16*NUM_REQ        per-engine writes issued minus responses received
//  overflow_err   out  1                 sticky: push into a full FIFO
// BEHAVIOUR
//  Reset: af2cp_sTx_c1.valid=0, req_sRx_c1[*].rspValid=0, req_almfull=all 1 for the reset cycle, then per formula.
//  Reset also clears FIFOs, outstanding=0, overflow_err=0, RR pointer=NUM_REQ-1 (first grant goes to req 0).
//  Push: req_sTx_c1[i].valid writes {hdr,data} into FIFO i, with hdr.mdata[ID_BITS-1:0] overwritten by i.
//  Push: upper mdata bits are kept; engines must not rely on low mdata bits in responses.
//  Overflow: a push into a full FIFO is dropped and sets overflow_err; it stays set until reset.
//  Pop: in a cycle with c1TxAlmFull=0, select the first non-empty FIFO scanning from RR pointer+1 modulo NUM_REQ.
//  Pop, at most one per cycle: register it onto af2cp_sTx_c1 (valid=1 next cycle), set the RR pointer to the winner, outstanding[winner]++.
//  Pop: c1TxAlmFull=1 -> no pop; valid=0. No combinational path from c1TxAlmFull to any output.
//  Latency: push cycle t -> earliest af2cp_sTx_c1.valid at t+2 (FIFO write t+1, registered issue t+2).
//  Same-cycle push+pop on one FIFO: fill unchanged; full FIFO with simultaneous pop still rejects the push.
//  Response: cp2af_sRx_c1.rspValid -> req_sRx_c1[mdata[ID_BITS-1:0]].rspValid=1 one cycle later, hdr copied.
//  Response: that engine's outstanding count decrements. Only single-line, unpacked responses (format=0) are supported.
//  Response tag >= NUM_REQ: dropped, no counter change.
//  Same-cycle issue and response for one engine: outstanding unchanged.
//  Counters: outstanding saturates at 0 and 16'hFFFF, never wraps.
//  Counters: responses arriving after a mid-operation reset are still routed, with counts held at 0.
//  State: the arbiter is stateless apart from FIFOs, RR pointer and counters; it has no FSM busy state.
//  State: every cycle is independent.
// CONFIGURATION
//  GLM_C1_ARB_STATS_EN defined:
//    adds outputs issued_lines[32*NUM_REQ] (pops per engine) and stall_cycles[32] (cycles with any FIFO non-empty and c1TxAlmFull=1).
//    Both counters clear on reset and wrap modulo 2^32.
//  GLM_C1_ARB_STATS_EN undefined: those ports and counters do not exist; all other behaviour is identical.
// TESTING
//  1) Single engine 0: 5 pushes in consecutive cycles -> 5 issues at t+2..t+6; addresses and data in order, mdata[1:0]=0.
//  1) Then 5 responses -> outstanding[0] goes 5 -> 0.
//  2) All 4 engines push 3 each in the same cycles -> issue order 0,1,2,3,0,1,2,3,0,1,2,3; no FIFO starves.
//  3) c1TxAlmFull held 10 cycles while engine 1 pushes 8 -> no valid during hold; req_almfull[1]=1 at fill 8.
//  3) Drains 8 in order after release.
//  4) Engine 2 pushes 17 ignoring almfull -> 16 issued, overflow_err=1 and sticky.
//  4) Response with mdata[1:0]=2 and another with tag 3 in successive cycles -> routed to req 2 and req 3 only.
//  5) Reset asserted with 6 queued and 4 outstanding -> no issue after reset; outstanding=0.
//  5) A late response is routed with its count held at 0; with STATS_EN, issued_lines=0.

Source files
------------

// File: rtl/glm_c1_write_arbiter.sv
// glm_c1_write_arbiter: shares one CCI-P c1 write channel among NUM_REQ engines.
// Each engine has its own request FIFO. A round-robin arbiter issues one
// registered write per cycle and writes the engine id into the low mdata bits.
// Write responses are routed back to the engine named by that tag, and the
// per-engine count of writes in flight is updated.
// Optional build macro GLM_C1_ARB_STATS_EN adds the issued_lines and
// stall_cycles counter outputs.

package glm_c1_arb_pkg;

   typedef struct packed {
      logic [1:0]  vc_sel;
      logic        sop;
      logic [1:0]  cl_len;
      logic [3:0]  req_type;
      logic [41:0] address;
      logic [15:0] mdata;
   } t_ccip_c1_ReqMemHdr;

   typedef struct packed {
      t_ccip_c1_ReqMemHdr hdr;
      logic [511:0]       data;
      logic               valid;
   } t_if_ccip_c1_Tx;

   typedef struct packed {
      logic [1:0]  vc_used;
      logic        hit_miss;
      logic        format;
      logic [1:0]  cl_num;
      logic [3:0]  resp_type;
      logic [15:0] mdata;
   } t_ccip_c1_RspMemHdr;

   typedef struct packed {
      t_ccip_c1_RspMemHdr hdr;
      logic               rspValid;
   } t_if_ccip_c1_Rx;

endpackage

module glm_c1_write_arbiter
   import glm_c1_arb_pkg::*;
#(
   parameter int NUM_REQ       = 4,
   parameter int FIFO_DEPTH    = 16,
   parameter int ALMFULL_SLACK = 8
)
(
   input  logic                    clk,
   input  logic                    reset,
   input  t_if_ccip_c1_Tx          req_sTx_c1 [NUM_REQ],
   output logic [NUM_REQ-1:0]      req_almfull,
   output t_if_ccip_c1_Rx          req_sRx_c1 [NUM_REQ],
   input  logic                    c1TxAlmFull,
   output t_if_ccip_c1_Tx          af2cp_sTx_c1,
   input  t_if_ccip_c1_Rx          cp2af_sRx_c1,
   output logic [16*NUM_REQ-1:0]   outstanding,
   output logic                    overflow_err
`ifdef GLM_C1_ARB_STATS_EN
   ,
   output logic [32*NUM_REQ-1:0]   issued_lines,
   output logic [31:0]             stall_cycles
`endif
);

   localparam int ID_BITS = $clog2(NUM_REQ);
   localparam int PTR_W   = $clog2(FIFO_DEPTH);
   localparam logic [PTR_W:0] L_FULL = (PTR_W+1)'(FIFO_DEPTH);
   localparam logic [PTR_W:0] L_AF   = (PTR_W+1)'(FIFO_DEPTH - ALMFULL_SLACK);
   localparam logic [ID_BITS-1:0] L_RR_INIT = ID_BITS'(NUM_REQ - 1);

   typedef struct packed {
      t_ccip_c1_ReqMemHdr hdr;
      logic [511:0]       data;
   } t_entry;

   t_entry              r_mem   [NUM_REQ][FIFO_DEPTH];
   logic [PTR_W:0]      r_wptr  [NUM_REQ];
   logic [PTR_W:0]      r_rptr  [NUM_REQ];
   logic [PTR_W:0]      w_fill  [NUM_REQ];
   t_entry              w_entry [NUM_REQ];
   logic [NUM_REQ-1:0]  w_empty;
   logic [NUM_REQ-1:0]  w_full;
   logic [NUM_REQ-1:0]  w_push;
   logic [NUM_REQ-1:0]  w_over;
   logic [NUM_REQ-1:0]  w_win_oh;
   logic [NUM_REQ-1:0]  w_rsp_hit;
   logic [ID_BITS-1:0]  r_rr;
   logic [ID_BITS-1:0]  w_win;
   logic [ID_BITS-1:0]  w_idx;
   logic                w_any;
   logic                w_pop;
   t_if_ccip_c1_Tx      r_tx;
   logic [NUM_REQ-1:0]  r_rsp_valid;
   t_ccip_c1_RspMemHdr  r_rsp_hdr;
   logic [15:0]         r_out   [NUM_REQ];
   logic                r_overflow;

   // FIFO status, push qualification, tagged entry, back-pressure and response decode
   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         w_fill[i]                          = r_wptr[i] - r_rptr[i];
         w_empty[i]                         = (w_fill[i] == '0);
         w_full[i]                          = (w_fill[i] == L_FULL);
         w_push[i]                          = req_sTx_c1[i].valid && !w_full[i];
         w_over[i]                          = req_sTx_c1[i].valid && w_full[i];
         req_almfull[i]                     = reset || (w_fill[i] >= L_AF);
         w_entry[i].hdr                     = req_sTx_c1[i].hdr;
         w_entry[i].hdr.mdata[ID_BITS-1:0]  = ID_BITS'(i);
         w_entry[i].data                    = req_sTx_c1[i].data;
         w_rsp_hit[i]                       = cp2af_sRx_c1.rspValid &&
                                              (cp2af_sRx_c1.hdr.mdata[ID_BITS-1:0] == ID_BITS'(i));
      end
   end

   // Round-robin pick: first non-empty FIFO after the last winner
   always_comb begin
      w_any = 1'b0;
      w_win = '0;
      w_idx = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         w_idx = ID_BITS'((int'(r_rr) + k) % NUM_REQ);
         if (!w_any && !w_empty[w_idx]) begin
            w_any = 1'b1;
            w_win = w_idx;
         end
      end
      w_pop = w_any && !c1TxAlmFull;
      for (int i = 0; i < NUM_REQ; i++)
         w_win_oh[i] = w_pop && (w_win == ID_BITS'(i));
   end

   // FIFO pointers and the sticky overflow flag; a full FIFO rejects a push even when popped
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            r_wptr[i] <= '0;
            r_rptr[i] <= '0;
         end
         r_overflow <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (w_push[i])
               r_wptr[i] <= r_wptr[i] + 1'b1;
            if (w_win_oh[i])
               r_rptr[i] <= r_rptr[i] + 1'b1;
         end
         if (|w_over)
            r_overflow <= 1'b1;
      end
   end

   // FIFO storage, no reset needed since pointers qualify every read
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_REQ; i++)
         if (w_push[i])
            r_mem[i][r_wptr[i][PTR_W-1:0]] <= w_entry[i];
   end

   // Registered issue stage and round-robin pointer
   always_ff @(posedge clk) begin
      if (reset) begin
         r_tx <= '0;
         r_rr <= L_RR_INIT;
      end else begin
         r_tx.valid <= w_pop;
         if (w_pop) begin
            r_tx.hdr  <= r_mem[w_win][r_rptr[w_win][PTR_W-1:0]].hdr;
            r_tx.data <= r_mem[w_win][r_rptr[w_win][PTR_W-1:0]].data;
            r_rr      <= w_win;
         end
      end
   end

   // Response routing: one-cycle registered copy of the shell response
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rsp_valid <= '0;
         r_rsp_hdr   <= '0;
      end else begin
         r_rsp_valid <= w_rsp_hit;
         r_rsp_hdr   <= cp2af_sRx_c1.hdr;
      end
   end

   // In-flight counters, saturating at both ends; issue and response together cancel
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_REQ; i++) begin
         if (reset)
            r_out[i] <= '0;
         else if (w_win_oh[i] && !w_rsp_hit[i] && r_out[i] != 16'hFFFF)
            r_out[i] <= r_out[i] + 16'd1;
         else if (w_rsp_hit[i] && !w_win_oh[i] && r_out[i] != 16'h0000)
            r_out[i] <= r_out[i] - 16'd1;
      end
   end

   // Output fan-out of the per-engine registers
   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         outstanding[16*i +: 16]   = r_out[i];
         req_sRx_c1[i].hdr         = r_rsp_hdr;
         req_sRx_c1[i].rspValid    = r_rsp_valid[i];
      end
   end

   assign af2cp_sTx_c1 = r_tx;
   assign overflow_err = r_overflow;

`ifdef GLM_C1_ARB_STATS_EN
   logic [31:0] r_issued [NUM_REQ];
   logic [31:0] r_stall;

   // Statistics: pops per engine and cycles stalled by the shell with work queued
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_REQ; i++)
            r_issued[i] <= '0;
         r_stall <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++)
            if (w_win_oh[i])
               r_issued[i] <= r_issued[i] + 32'd1;
         if (!(&w_empty) && c1TxAlmFull)
            r_stall <= r_stall + 32'd1;
      end
   end

   // Statistics output packing
   always_comb begin
      for (int i = 0; i < NUM_REQ; i++)
         issued_lines[32*i +: 32] = r_issued[i];
   end

   assign stall_cycles = r_stall;
`endif

endmodule
